// File: rtl/alu_issue_if.sv
// Bundle between fetch, the alu_issue sequencer, the external alu and writeback consumers.
// ALUOP codes live here so every user of the interface sees the same encoding.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`define ALUOP_ADD  4'd0
`define ALUOP_SUB  4'd1
`define ALUOP_SLL  4'd2
`define ALUOP_SLT  4'd3
`define ALUOP_SLTU 4'd4
`define ALUOP_XOR  4'd5
`define ALUOP_SRL  4'd6
`define ALUOP_SRA  4'd7
`define ALUOP_OR   4'd8
`define ALUOP_AND  4'd9
`endif

interface alu_issue_if;
   logic                    instr_valid;
   logic                    instr_ready;
   logic [31:0]             instr;
   logic [`ALUOP_WIDTH-1:0] alu_op;
   logic [31:0]             alu_a;
   logic [31:0]             alu_b;
   logic [31:0]             alu_res;
   logic                    wb_valid;
   logic [4:0]              wb_addr;
   logic [31:0]             wb_data;
   logic                    err;

   modport master (
      input  instr_valid, instr, alu_res,
      output instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err
   );

   modport slave (
      output instr_valid, instr, alu_res,
      input  instr_ready, alu_op, alu_a, alu_b, wb_valid, wb_addr, wb_data, err
   );
endinterface

// File: rtl/alu_issue.sv
// Single-issue RV32I OP/OP-IMM execute sequencer: decode, read regfile, drive an external
// alu, capture its result and write it back (IDLE -> EXEC -> WB, illegal: IDLE -> EXEC).
module alu_issue #(
   parameter int REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.master bus,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t                  state;
   logic [31:0]             rf [REGS];
   logic [4:0]              rd_q;
   logic                    ill_q;

   logic [6:0]              opcode;
   logic [6:0]              funct7;
   logic [2:0]              funct3;
   logic [4:0]              rd;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic                    is_op;
   logic                    is_imm;
   logic                    alt;
   logic                    dec_ill;
   logic [`ALUOP_WIDTH-1:0] dec_op;
   logic [31:0]             dec_a;
   logic [31:0]             dec_b;

   function automatic logic in_range(input logic [4:0] idx);
      return 32'(idx) < 32'(REGS);
   endfunction

   // x0 and out-of-range indices read as zero
   function automatic logic [31:0] rd_reg(input logic [4:0] idx);
      if (idx == '0 || !in_range(idx))
         return '0;
      return rf[idx[IW-1:0]];
   endfunction

   assign opcode = bus.instr[6:0];
   assign rd     = bus.instr[11:7];
   assign funct3 = bus.instr[14:12];
   assign rs1    = bus.instr[19:15];
   assign rs2    = bus.instr[24:20];
   assign funct7 = bus.instr[31:25];
   assign is_op  = (opcode == 7'b0110011);
   assign is_imm = (opcode == 7'b0010011);
   assign alt    = (funct7 == 7'b0100000);

   always_comb begin
      dec_op = `ALUOP_ADD;
      case (funct3)
         3'b000: dec_op = (is_op && alt) ? `ALUOP_SUB : `ALUOP_ADD;
         3'b001: dec_op = `ALUOP_SLL;
         3'b010: dec_op = `ALUOP_SLT;
         3'b011: dec_op = `ALUOP_SLTU;
         3'b100: dec_op = `ALUOP_XOR;
         3'b101: dec_op = alt ? `ALUOP_SRA : `ALUOP_SRL;
         3'b110: dec_op = `ALUOP_OR;
         default: dec_op = `ALUOP_AND;
      endcase

      dec_ill = 1'b0;
      if (is_op)
         dec_ill = !(funct7 == 7'b0000000 || (alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      else if (is_imm) begin
         // only the shift-immediates constrain instr[31:25]
         if (funct3 == 3'b001)
            dec_ill = (funct7 != 7'b0000000);
         else if (funct3 == 3'b101)
            dec_ill = !(funct7 == 7'b0000000 || alt);
      end else
         dec_ill = 1'b1;
      if (!in_range(rd) || !in_range(rs1) || (is_op && !in_range(rs2)))
         dec_ill = 1'b1;

      dec_a = rd_reg(rs1);
      dec_b = is_op ? rd_reg(rs2) : {{20{bus.instr[31]}}, bus.instr[31:20]};
   end

   assign bus.instr_ready = (state == IDLE);
   assign dbg_data        = rd_reg(dbg_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rf           <= '{default: '0};
         bus.alu_op   <= `ALUOP_ADD;
         bus.alu_a    <= '0;
         bus.alu_b    <= '0;
         bus.wb_valid <= 1'b0;
         bus.wb_addr  <= '0;
         bus.wb_data  <= '0;
         bus.err      <= 1'b0;
         rd_q         <= '0;
         ill_q        <= 1'b0;
      end else begin
         bus.wb_valid <= 1'b0;
         bus.err      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.instr_valid) begin
                  bus.alu_op <= dec_op;
                  bus.alu_a  <= dec_a;
                  bus.alu_b  <= dec_b;
                  rd_q       <= rd;
                  ill_q      <= dec_ill;
                  bus.err    <= dec_ill;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (ill_q)
                  state <= IDLE;
               else begin
                  bus.wb_data  <= bus.alu_res;
                  bus.wb_addr  <= rd_q;
                  bus.wb_valid <= 1'b1;
                  state        <= WB;
               end
            end
            WB: begin
               if (bus.wb_addr != '0)
                  rf[bus.wb_addr[IW-1:0]] <= bus.wb_data;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: an environment alu feeds both an RV32I and an RV32E instance, and a
// register-level reference model of the instruction set predicts every writeback.
`ifndef ALUOP_WIDTH
`define ALUOP_WIDTH 4
`define ALUOP_ADD  4'd0
`define ALUOP_SUB  4'd1
`define ALUOP_SLL  4'd2
`define ALUOP_SLT  4'd3
`define ALUOP_SLTU 4'd4
`define ALUOP_XOR  4'd5
`define ALUOP_SRL  4'd6
`define ALUOP_SRA  4'd7
`define ALUOP_OR   4'd8
`define ALUOP_AND  4'd9
`endif

module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        drv_valid = 1'b0;
   logic [31:0] drv_instr = '0;
   logic [4:0]  drv_dbg = '0;
   bit          tb_sel = 1'b0;
   logic [31:0] dbg32, dbg16;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] ref_rf [2][32];

   logic        m_ready, m_err, m_wb_valid;
   logic [4:0]  m_wb_addr;
   logic [31:0] m_wb_data, m_dbg;

   alu_issue_if bus32();
   alu_issue_if bus16();

   alu_issue #(.REGS(32)) u32 (.clk(clk), .rst(rst), .bus(bus32), .dbg_addr(drv_dbg), .dbg_data(dbg32));
   alu_issue #(.REGS(16)) u16 (.clk(clk), .rst(rst), .bus(bus16), .dbg_addr(drv_dbg), .dbg_data(dbg16));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] alu_fn(input logic [`ALUOP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         `ALUOP_ADD:  return a + b;
         `ALUOP_SUB:  return a - b;
         `ALUOP_SLL:  return a << b[4:0];
         `ALUOP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         `ALUOP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         `ALUOP_XOR:  return a ^ b;
         `ALUOP_SRL:  return a >> b[4:0];
         `ALUOP_SRA:  return $signed(a) >>> b[4:0];
         `ALUOP_OR:   return a | b;
         `ALUOP_AND:  return a & b;
         default:     return 32'd0;
      endcase
   endfunction

   always_comb begin
      bus32.instr_valid = drv_valid && !tb_sel;
      bus32.instr       = drv_instr;
      bus32.alu_res     = alu_fn(bus32.alu_op, bus32.alu_a, bus32.alu_b);
      bus16.instr_valid = drv_valid && tb_sel;
      bus16.instr       = drv_instr;
      bus16.alu_res     = alu_fn(bus16.alu_op, bus16.alu_a, bus16.alu_b);
      m_ready    = tb_sel ? bus16.instr_ready : bus32.instr_ready;
      m_err      = tb_sel ? bus16.err         : bus32.err;
      m_wb_valid = tb_sel ? bus16.wb_valid    : bus32.wb_valid;
      m_wb_addr  = tb_sel ? bus16.wb_addr     : bus32.wb_addr;
      m_wb_data  = tb_sel ? bus16.wb_data     : bus32.wb_data;
      m_dbg      = tb_sel ? dbg16             : dbg32;
   end

   function automatic logic [31:0] ref_rd(input bit s, input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : ref_rf[s][r];
   endfunction

   // Architectural effect of one instruction on the register file of instance s
   function automatic void ref_eval(input bit s, input logic [31:0] ins, output bit legal,
                                    output logic [4:0] rd, output logic [31:0] val);
      int regs, sh;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      logic [4:0] r1, r2;
      logic [31:0] a, b;
      bit alt;
      regs = s ? 16 : 32;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
      alt = (f7 == 7'h20);
      if (opc == 7'h33)
         legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      else if (opc == 7'h13)
         legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || alt) : 1'b1;
      else
         legal = 1'b0;
      if (int'(rd) >= regs || int'(r1) >= regs || (opc == 7'h33 && int'(r2) >= regs))
         legal = 1'b0;
      a = ref_rd(s, r1);
      b = (opc == 7'h33) ? ref_rd(s, r2) : {{20{ins[31]}}, ins[31:20]};
      sh = int'(b[4:0]);
      case (f3)
         3'd0: val = (opc == 7'h33 && alt) ? a - b : a + b;
         3'd1: val = a << sh;
         3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: val = (a < b) ? 32'd1 : 32'd0;
         3'd4: val = a ^ b;
         3'd5: val = alt ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: val = a | b;
         default: val = a & b;
      endcase
   endfunction

   function automatic void ref_apply(input bit s, input logic [31:0] ins);
      bit legal; logic [4:0] rd; logic [31:0] val;
      ref_eval(s, ins, legal, rd, val);
      if (legal && rd != 5'd0)
         ref_rf[s][rd] = val;
   endfunction

   function automatic void ref_clear();
      for (int i = 0; i < 32; i++) begin
         ref_rf[0][i] = '0;
         ref_rf[1][i] = '0;
      end
   endfunction

   task automatic issue(input bit s, input logic [31:0] ins, input string tag, output logic [31:0] obs);
      bit legal; logic [4:0] rd; logic [31:0] val; int n;
      ref_eval(s, ins, legal, rd, val);
      obs = '0;
      tb_sel = s;
      @(negedge clk);
      drv_instr = ins;
      drv_valid = 1'b1;
      n = 0;
      while (m_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (n >= 10) begin
         errors++; $display("FAIL %s ready_timeout got instr_ready=%b want 1", tag, m_ready);
         drv_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      drv_valid = 1'b0;
      checks++; if (m_err !== (legal ? 1'b0 : 1'b1)) begin errors++; $display("FAIL %s exec_err got %b want %b", tag, m_err, !legal); end
      checks++; if (m_wb_valid !== 1'b0) begin errors++; $display("FAIL %s exec_wb_valid got %b want 0", tag, m_wb_valid); end
      checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL %s exec_ready got %b want 0", tag, m_ready); end
      @(posedge clk); #1;
      if (legal) begin
         checks++; if (m_wb_valid !== 1'b1) begin errors++; $display("FAIL %s wb_valid got %b want 1", tag, m_wb_valid); end
         checks++; if (m_wb_addr !== rd) begin errors++; $display("FAIL %s wb_addr got %0d want %0d", tag, m_wb_addr, rd); end
         checks++; if (m_wb_data !== val) begin errors++; $display("FAIL %s wb_data got %h want %h", tag, m_wb_data, val); end
         checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL %s wb_ready got %b want 0", tag, m_ready); end
         obs = m_wb_data;
         ref_apply(s, ins);
         @(posedge clk); #1;
         checks++; if (m_wb_valid !== 1'b0) begin errors++; $display("FAIL %s wb_pulse_len got %b want 0", tag, m_wb_valid); end
      end else begin
         checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL %s err_pulse_len got %b want 0", tag, m_err); end
         checks++; if (m_wb_valid !== 1'b0) begin errors++; $display("FAIL %s illegal_wb got %b want 0", tag, m_wb_valid); end
      end
      checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got %b want 1", tag, m_ready); end
      drv_dbg = rd; #1;
      checks++; if (m_dbg !== ref_rd(s, rd)) begin errors++; $display("FAIL %s dbg_rd got %h want %h", tag, m_dbg, ref_rd(s, rd)); end
   endtask

   task automatic check_regs(input bit s, input string tag);
      logic [31:0] exp;
      tb_sel = s;
      for (int r = 0; r < 32; r++) begin
         drv_dbg = 5'(r); #1;
         exp = (r >= (s ? 16 : 32)) ? 32'd0 : ref_rd(s, 5'(r));
         checks++;
         if (m_dbg !== exp) begin errors++; $display("FAIL %s dbg_x%0d got %h want %h", tag, r, m_dbg, exp); end
      end
   endtask

   task automatic test_reset();
      tb_sel = 1'b0;
      #1;
      checks++; if (bus32.alu_op !== `ALUOP_ADD) begin errors++; $display("FAIL reset_alu_op got %0d want %0d", bus32.alu_op, `ALUOP_ADD); end
      checks++; if (bus32.alu_a !== 32'd0 || bus32.alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_ab got %h/%h want 0/0", bus32.alu_a, bus32.alu_b); end
      checks++; if (bus32.wb_valid !== 1'b0 || bus32.err !== 1'b0) begin errors++; $display("FAIL reset_pulses got wb_valid=%b err=%b want 0/0", bus32.wb_valid, bus32.err); end
      checks++; if (bus32.wb_addr !== 5'd0 || bus32.wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb got %0d/%h want 0/0", bus32.wb_addr, bus32.wb_data); end
      checks++; if (bus32.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus32.instr_ready); end
      check_regs(1'b0, "reset_regs");
   endtask

   task automatic test_directed();
      logic [31:0] obs;
      issue(1'b0, 32'h00500093, "addi_x1", obs);
      checks++; if (obs !== 32'd5) begin errors++; $display("FAIL addi_x1_val got %h want 5", obs); end
      issue(1'b0, 32'h00108133, "add_x2", obs);
      checks++; if (obs !== 32'd10) begin errors++; $display("FAIL add_x2_val got %h want a", obs); end
      issue(1'b0, 32'h401001B3, "sub_x3", obs);
      checks++; if (obs !== 32'hFFFFFFFB) begin errors++; $display("FAIL sub_x3_val got %h want fffffffb", obs); end
      issue(1'b0, 32'h4011D213, "srai_x4", obs);
      checks++; if (obs !== 32'hFFFFFFFD) begin errors++; $display("FAIL srai_x4_val got %h want fffffffd", obs); end
      issue(1'b0, 32'h0011A2B3, "slt_x5", obs);
      checks++; if (obs !== 32'd1) begin errors++; $display("FAIL slt_x5_val got %h want 1", obs); end
      issue(1'b0, 32'h0011B2B3, "sltu_x5", obs);
      checks++; if (obs !== 32'd0) begin errors++; $display("FAIL sltu_x5_val got %h want 0", obs); end
      issue(1'b0, 32'h00700013, "addi_x0", obs);
      checks++; if (obs !== 32'd7) begin errors++; $display("FAIL addi_x0_data got %h want 7", obs); end
   endtask

   task automatic test_illegal();
      logic [31:0] obs;
      issue(1'b0, 32'h00000073, "ecall", obs);
      issue(1'b0, 32'h02108133, "funct7_1", obs);
      issue(1'b0, 32'h40109093, "slli_alt", obs);
      check_regs(1'b0, "illegal_regs");
   endtask

   task automatic test_regs16();
      logic [31:0] obs;
      issue(1'b1, 32'h00900793, "e_addi_x15", obs);
      checks++; if (obs !== 32'd9) begin errors++; $display("FAIL e_addi_x15_val got %h want 9", obs); end
      issue(1'b1, 32'h00100813, "e_rd_x16", obs);
      issue(1'b1, 32'h00088093, "e_rs1_x17", obs);
      issue(1'b1, 32'h014080B3, "e_rs2_x20", obs);
      check_regs(1'b1, "e_regs");
   endtask

   task automatic test_random();
      logic [31:0] ins, obs;
      int kind, f;
      for (int k = 0; k < 150; k++) begin
         kind = $urandom_range(0, 9);
         ins = $urandom;
         if (kind < 4) ins[6:0] = 7'h33;
         else if (kind < 8) ins[6:0] = 7'h13;
         if (kind < 8) begin
            f = $urandom_range(0, 5);
            if (f < 3) ins[31:25] = 7'h00;
            else if (f < 5) ins[31:25] = 7'h20;
         end
         issue(1'b0, ins, "rand", obs);
      end
      check_regs(1'b0, "rand_regs");
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [4];
      int t [4];
      int n;
      prog[0] = 32'h00300393; prog[1] = 32'h00738433;
      prog[2] = 32'h007404B3; prog[3] = 32'h40848533;
      tb_sel = 1'b0;
      @(negedge clk);
      drv_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drv_instr = prog[k];
         n = 0;
         while (m_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
         if (n >= 10) begin
            checks++; errors++;
            $display("FAIL b2b_timeout got instr_ready=%b want 1", m_ready);
            break;
         end
         t[k] = cyc;
         ref_apply(1'b0, prog[k]);
         @(posedge clk); #1;
         if (k > 0) begin
            checks++;
            if (t[k] - t[k-1] != 3) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 3", k, t[k] - t[k-1]); end
         end
      end
      drv_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      drv_dbg = 5'd10; #1;
      checks++; if (m_dbg !== 32'd3) begin errors++; $display("FAIL b2b_x10 got %h want 3", m_dbg); end
      check_regs(1'b0, "b2b_regs");
   endtask

   task automatic test_reset_mid();
      int n;
      tb_sel = 1'b0;
      @(negedge clk);
      drv_instr = 32'h05500313;
      drv_valid = 1'b1;
      n = 0;
      while (m_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      drv_valid = 1'b0;
      rst = 1'b1; #1;
      checks++; if (m_wb_valid !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses got wb_valid=%b err=%b want 0/0", m_wb_valid, m_err); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      ref_clear();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checks++; if (m_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_wb%0d got %b want 0", c, m_wb_valid); end
         checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready%0d got %b want 1", c, m_ready); end
      end
      check_regs(1'b0, "rst_mid_regs");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

   initial begin
      ref_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_directed();
      test_illegal();
      test_regs16();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
